// File: rtl/change_if.sv
// Handshake, hopper drive and sensor bundle between the vending FSM/hoppers
// and the change dispenser.
interface change_if #(
   parameter int AMT_W = 4
) ();
   logic             req_valid;
   logic [AMT_W-1:0] req_amount;
   logic             req_ready;
   logic             hop10_en;
   logic             hop5_en;
   logic             sense10;
   logic             sense5;
   logic             busy;
   logic             done;
   logic             fault;
   logic [AMT_W-1:0] paid;

   modport master (
      output req_valid, req_amount, sense10, sense5,
      input  req_ready, hop10_en, hop5_en, busy, done, fault, paid
   );

   modport slave (
      input  req_valid, req_amount, sense10, sense5,
      output req_ready, hop10_en, hop5_en, busy, done, fault, paid
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout controller: drives 10/5-unit hoppers one coin at a time,
// confirms each coin on the exit sensors and reports paid amount and faults.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request
// SELECT  | pick 10-unit coin if remaining>=2 else 5-unit, load timers
// DRIVE   | selected hopper motor on for PULSE_CYC cycles, sensor watched
// WAIT    | motors off, waiting for the selected coin's sensor
// DONE    | one-cycle completion pulse, no fault
// FAULT   | one-cycle completion pulse with fault (jam or timeout)
module change_dispenser #(
   parameter int AMT_W       = 4,
   parameter int PULSE_CYC   = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic    clk,
   input  logic    rst,
   change_if.slave bus
);

   localparam int PUL_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_DRIVE,
      S_WAIT,
      S_DONE,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [AMT_W-1:0] paid_q, paid_d;
   logic             fault_q, fault_d;
   logic             coin10_q, coin10_d;
   logic [PUL_W-1:0] pulse_q, pulse_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic [AMT_W-1:0] coin_val;
   logic             hit;
   logic             jam;

   assign coin_val = coin10_q ? AMT_W'(2) : AMT_W'(1);
   assign hit      = coin10_q ? (bus.sense10 & ~bus.sense5) : (bus.sense5 & ~bus.sense10);
   assign jam      = (bus.sense10 | bus.sense5) & ~hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         paid_q   <= '0;
         fault_q  <= 1'b0;
         coin10_q <= 1'b0;
         pulse_q  <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         paid_q   <= paid_d;
         fault_q  <= fault_d;
         coin10_q <= coin10_d;
         pulse_q  <= pulse_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      paid_d   = paid_q;
      fault_d  = fault_q;
      coin10_d = coin10_q;
      pulse_d  = pulse_q;
      tmo_d    = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               rem_d   = bus.req_amount;
               paid_d  = '0;
               fault_d = 1'b0;
               state_d = (bus.req_amount == '0) ? S_DONE : S_SELECT;
            end
         end
         S_SELECT: begin
            coin10_d = (rem_q >= AMT_W'(2));
            pulse_d  = PUL_W'(PULSE_CYC - 1);
            tmo_d    = TMO_W'(TIMEOUT_CYC - 1);
            state_d  = S_DRIVE;
         end
         S_DRIVE, S_WAIT: begin
            // A matching sensor in the final timeout cycle still counts as success.
            if (hit) begin
               rem_d   = rem_q - coin_val;
               paid_d  = paid_q + coin_val;
               state_d = (rem_q == coin_val) ? S_DONE : S_SELECT;
            end else if (jam || tmo_q == '0) begin
               fault_d = 1'b1;
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q - 1'b1;
               if (state_q == S_DRIVE) begin
                  if (pulse_q == '0) state_d = S_WAIT;
                  else               pulse_d = pulse_q - 1'b1;
               end
            end
         end
         S_DONE, S_FAULT: state_d = S_IDLE;
         default:         state_d = S_IDLE;
      endcase
   end

   assign bus.req_ready = (state_q == S_IDLE) && !rst;
   assign bus.hop10_en  = (state_q == S_DRIVE) && coin10_q;
   assign bus.hop5_en   = (state_q == S_DRIVE) && !coin10_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE) || (state_q == S_FAULT);
   assign bus.fault     = fault_q;
   assign bus.paid      = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_CYC=4, TIMEOUT_CYC=20, AMT_W=4.
module tb_change_dispenser;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   change_if #(.AMT_W(4)) bus ();

   change_dispenser #(.AMT_W(4), .PULSE_CYC(4), .TIMEOUT_CYC(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one request at the current negedge and plays the hoppers: a sensor
   // pulse follows each motor burst after dN cycles (-1 = never, wrong = other coin).
   task automatic serve(input logic [3:0] amt, input int d10, input int d5,
                        input bit wrong, input bit spam, input int budget,
                        output bit got_done, output int done_cyc, output int first_en,
                        output int n10, output int n5, output int minlen, output int maxlen,
                        output logic [3:0] paid_o, output logic fault_o,
                        output logic fault_c1, output logic ready_t, output bit overlap);
      int cyc, len10, len5, cnt10, cnt5;
      got_done = 0; done_cyc = -1; first_en = -1; n10 = 0; n5 = 0;
      minlen = 1000; maxlen = 0; paid_o = 'x; fault_o = 'x; fault_c1 = 'x;
      overlap = 0; len10 = 0; len5 = 0; cnt10 = -1; cnt5 = -1; cyc = 0;
      ready_t = bus.req_ready;
      bus.req_valid = 1'b1;
      bus.req_amount = amt;
      while (!got_done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         bus.sense10 = 1'b0;
         bus.sense5  = 1'b0;
         if (cyc == 1) fault_c1 = bus.fault;
         if ((bus.hop10_en || bus.hop5_en) && first_en < 0) first_en = cyc;
         if (bus.hop10_en && bus.hop5_en) overlap = 1;
         if (bus.hop10_en) len10++;
         else if (len10 > 0) begin
            n10++;
            if (len10 < minlen) minlen = len10;
            if (len10 > maxlen) maxlen = len10;
            len10 = 0;
            cnt10 = d10;
         end
         if (bus.hop5_en) len5++;
         else if (len5 > 0) begin
            n5++;
            if (len5 < minlen) minlen = len5;
            if (len5 > maxlen) maxlen = len5;
            len5 = 0;
            cnt5 = d5;
         end
         if (cnt10 == 0) begin
            if (wrong) bus.sense5 = 1'b1; else bus.sense10 = 1'b1;
         end
         if (cnt10 >= 0) cnt10--;
         if (cnt5 == 0) begin
            if (wrong) bus.sense10 = 1'b1; else bus.sense5 = 1'b1;
         end
         if (cnt5 >= 0) cnt5--;
         if (bus.done) begin
            got_done = 1; done_cyc = cyc; paid_o = bus.paid; fault_o = bus.fault;
         end
         bus.req_valid  = spam && !got_done && bus.busy && (cyc % 3 == 0);
         bus.req_amount = spam ? 4'd1 : amt;
      end
      bus.req_valid = 1'b0;
      bus.sense10   = 1'b0;
      bus.sense5    = 1'b0;
   endtask

   bit         g_done, g_ovl;
   int         g_dc, g_fe, g_n10, g_n5, g_min, g_max;
   logic [3:0] g_paid;
   logic       g_fault, g_fc1, g_rdy;

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_amount = '0; bus.sense10 = 1'b0; bus.sense5 = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({bus.req_ready, bus.busy, bus.done, bus.fault, bus.hop10_en, bus.hop5_en} !== 6'b0) begin
         n_bad++; $display("FAIL reset_flags got=%b want=000000",
            {bus.req_ready, bus.busy, bus.done, bus.fault, bus.hop10_en, bus.hop5_en}); end
      n_cmp++; if (bus.paid !== 4'd0) begin n_bad++; $display("FAIL reset_paid got=%0d want=0", bus.paid); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after got=%b want=1", bus.req_ready); end
   endtask

   task automatic test_mixed_coins();
      serve(4'd3, 2, 2, 0, 0, 100, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_rdy !== 1'b1) begin n_bad++; $display("FAIL mixed_ready got=%b want=1", g_rdy); end
      n_cmp++; if (g_done !== 1'b1) begin n_bad++; $display("FAIL mixed_done_timeout got=%0d want=1", g_done); end
      n_cmp++; if (g_fe !== 2) begin n_bad++; $display("FAIL mixed_first_enable got=%0d want=2", g_fe); end
      n_cmp++; if (g_dc !== 17) begin n_bad++; $display("FAIL mixed_done_cycle got=%0d want=17", g_dc); end
      n_cmp++; if (g_n10 !== 1 || g_n5 !== 1) begin n_bad++; $display("FAIL mixed_bursts got=%0d/%0d want=1/1", g_n10, g_n5); end
      n_cmp++; if (g_min !== 4 || g_max !== 4) begin n_bad++; $display("FAIL mixed_burst_len got=%0d..%0d want=4..4", g_min, g_max); end
      n_cmp++; if (g_paid !== 4'd3 || g_fault !== 1'b0) begin n_bad++; $display("FAIL mixed_result got=paid %0d fault %b want=paid 3 fault 0", g_paid, g_fault); end
      n_cmp++; if (g_ovl !== 1'b0) begin n_bad++; $display("FAIL mixed_overlap got=%0d want=0", g_ovl); end
   endtask

   task automatic test_zero_amount();
      serve(4'd0, 0, 0, 0, 0, 20, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_dc !== 1) begin n_bad++; $display("FAIL zero_done_cycle got=%0d want=1", g_dc); end
      n_cmp++; if (g_fe !== -1) begin n_bad++; $display("FAIL zero_no_enable got=%0d want=-1", g_fe); end
      n_cmp++; if (g_paid !== 4'd0 || g_fault !== 1'b0) begin n_bad++; $display("FAIL zero_result got=paid %0d fault %b want=paid 0 fault 0", g_paid, g_fault); end
   endtask

   task automatic test_timeout();
      serve(4'd2, -1, -1, 0, 0, 60, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_dc !== 22) begin n_bad++; $display("FAIL timeout_done_cycle got=%0d want=22", g_dc); end
      n_cmp++; if (g_n10 !== 1 || g_max !== 4) begin n_bad++; $display("FAIL timeout_burst got=%0d x%0d want=1 x4", g_n10, g_max); end
      n_cmp++; if (g_paid !== 4'd0 || g_fault !== 1'b1) begin n_bad++; $display("FAIL timeout_result got=paid %0d fault %b want=paid 0 fault 1", g_paid, g_fault); end
      @(negedge clk);
      n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky got=%b want=1", bus.fault); end
      serve(4'd1, 0, 0, 0, 0, 40, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_fc1 !== 1'b0) begin n_bad++; $display("FAIL timeout_clear_on_accept got=%b want=0", g_fc1); end
      n_cmp++; if (g_dc !== 7 || g_paid !== 4'd1 || g_n5 !== 1) begin n_bad++; $display("FAIL single5 got=cyc %0d paid %0d n5 %0d want=cyc 7 paid 1 n5 1", g_dc, g_paid, g_n5); end
   endtask

   task automatic test_jam();
      serve(4'd2, 1, 1, 1, 0, 40, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_dc !== 8) begin n_bad++; $display("FAIL jam_done_cycle got=%0d want=8", g_dc); end
      n_cmp++; if (g_paid !== 4'd0 || g_fault !== 1'b1) begin n_bad++; $display("FAIL jam_result got=paid %0d fault %b want=paid 0 fault 1", g_paid, g_fault); end
   endtask

   task automatic test_expiry_boundary();
      serve(4'd2, 15, 15, 0, 0, 60, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_dc !== 22 || g_paid !== 4'd2 || g_fault !== 1'b0) begin n_bad++; $display("FAIL expiry_wins got=cyc %0d paid %0d fault %b want=cyc 22 paid 2 fault 0", g_dc, g_paid, g_fault); end
      @(negedge clk);
      serve(4'd2, 16, 16, 0, 0, 60, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_dc !== 22 || g_paid !== 4'd0 || g_fault !== 1'b1) begin n_bad++; $display("FAIL expiry_late got=cyc %0d paid %0d fault %b want=cyc 22 paid 0 fault 1", g_dc, g_paid, g_fault); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      serve(4'd15, 0, 0, 0, 1, 200, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_n10 !== 7 || g_n5 !== 1) begin n_bad++; $display("FAIL full_bursts got=%0d/%0d want=7/1", g_n10, g_n5); end
      n_cmp++; if (g_dc !== 49 || g_paid !== 4'd15 || g_fault !== 1'b0) begin n_bad++; $display("FAIL full_result got=cyc %0d paid %0d fault %b want=cyc 49 paid 15 fault 0", g_dc, g_paid, g_fault); end
      @(negedge clk);
      serve(4'd2, 0, 0, 0, 0, 40, g_done, g_dc, g_fe, g_n10, g_n5, g_min, g_max, g_paid, g_fault, g_fc1, g_rdy, g_ovl);
      n_cmp++; if (g_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got=%b want=1", g_rdy); end
      n_cmp++; if (g_dc !== 7 || g_paid !== 4'd2 || g_n10 !== 1) begin n_bad++; $display("FAIL b2b_result got=cyc %0d paid %0d n10 %0d want=cyc 7 paid 2 n10 1", g_dc, g_paid, g_n10); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_drive();
      bit saw_done;
      saw_done = 0;
      bus.req_valid = 1'b1; bus.req_amount = 4'd3;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         bus.sense10 = (c == 6);
         if (bus.done) saw_done = 1;
      end
      n_cmp++; if (bus.hop5_en !== 1'b1 || bus.paid !== 4'd2) begin n_bad++; $display("FAIL rstmid_pre got=hop5 %b paid %0d want=hop5 1 paid 2", bus.hop5_en, bus.paid); end
      rst = 1'b1;
      @(negedge clk);
      if (bus.done) saw_done = 1;
      n_cmp++; if ({bus.hop10_en, bus.hop5_en, bus.busy, bus.req_ready, bus.fault} !== 5'b0 || bus.paid !== 4'd0) begin
         n_bad++; $display("FAIL rstmid_outputs got=%b paid %0d want=00000 paid 0",
            {bus.hop10_en, bus.hop5_en, bus.busy, bus.req_ready, bus.fault}, bus.paid); end
      rst = 1'b0;
      @(negedge clk);
      if (bus.done) saw_done = 1;
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b want=1", bus.req_ready); end
      n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done got=%0d want=0", saw_done); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_mixed_coins();
      @(negedge clk);
      test_zero_amount();
      @(negedge clk);
      test_timeout();
      @(negedge clk);
      test_jam();
      @(negedge clk);
      test_expiry_boundary();
      test_back_to_back();
      test_reset_mid_drive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
